uart_rx_fifo: RTL and testbench

Receive buffer sitting directly downstream of the UART receiver. Accepts each completed byte plus its framing-error flag through a valid/ready handshake and stores it in a first-word-fall-through FIFO. Presents the byte to the host side through a second valid/ready handshake. Reports drops caused by a full buffer through a sticky overflow flag, because the serial line cannot be back-pressured.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_rx_fifo_if.sv | 30 +++
 rtl/uart_fifo_mem.sv | 33 +++
 rtl/uart_rx_fifo.sv | 89 ++++++++
 tb/tb_uart_rx_fifo.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART receive-path constants and types
//
// UART_BIT_WIDTH  : default data bits per character, shared with the receiver
// uart_rx_entry_t : one buffered character, framing-error flag above the data
package uart_pkg;

  localparam int UART_BIT_WIDTH = 8;

  typedef struct packed {
    logic                      err;
    logic [UART_BIT_WIDTH-1:0] data;
  } uart_rx_entry_t;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - receiver-side and host-side byte handshakes of the RX FIFO
//
// in_byte/in_err/in_valid/in_ready     : receiver -> FIFO character stream
// out_byte/out_err/out_valid/out_ready : FIFO -> host character stream
// master : the receiver and host (drive in_* and out_ready)
// slave  : the FIFO
interface uart_rx_fifo_if import uart_pkg::*; #(
  parameter int BIT_WIDTH = UART_BIT_WIDTH
);

  logic [BIT_WIDTH-1:0] in_byte;
  logic                 in_err;
  logic                 in_valid;
  logic                 in_ready;
  logic [BIT_WIDTH-1:0] out_byte;
  logic                 out_err;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output in_byte, in_err, in_valid, out_ready,
    input  in_ready, out_byte, out_err, out_valid
  );

  modport slave (
    input  in_byte, in_err, in_valid, out_ready,
    output in_ready, out_byte, out_err, out_valid
  );

endinterface

// File: rtl/uart_fifo_mem.sv
// rtl/uart_fifo_mem.sv - DEPTH x WIDTH storage, synchronous write, asynchronous read
//
// clk   : write clock
// we    : write enable
// waddr : write address
// wdata : write data
// raddr : read address
// rdata : read data (combinational from raddr)
// The array is deliberately not reset; the FIFO's count qualifies every read.
module uart_fifo_mem #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - first-word-fall-through receive buffer with sticky overflow
//
// clk          : single clock, rising edge
// rst          : asynchronous active-low reset
// bus          : slave side of uart_rx_fifo_if (receiver in, host out)
// count        : entries currently stored
// overflow     : sticky, set when a character is dropped because the buffer is full
// clr_overflow : synchronous clear of overflow (a coincident drop wins)
module uart_rx_fifo import uart_pkg::*; #(
  parameter int BIT_WIDTH = UART_BIT_WIDTH,
  parameter int DEPTH     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  uart_rx_fifo_if.slave          bus,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  input  logic                   clr_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [AW-1:0]      wptr;
  logic [AW-1:0]      rptr;
  logic               full;
  logic               empty;
  logic               wr_en;
  logic               rd_en;
  logic               drop;
  logic [BIT_WIDTH:0] wdata;
  logic [BIT_WIDTH:0] rdata;

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);

  // A full buffer still accepts when the host frees the head slot this cycle.
  assign bus.in_ready  = !full || bus.out_ready;
  assign bus.out_valid = !empty;

  assign wr_en = bus.in_valid && bus.in_ready;
  assign rd_en = !empty && bus.out_ready;
  assign drop  = bus.in_valid && !bus.in_ready;

  assign wdata = {bus.in_err, bus.in_byte};

  // Stale storage is masked so an empty buffer presents all zeros.
  assign {bus.out_err, bus.out_byte} = empty ? '0 : rdata;

  uart_fifo_mem #(
    .WIDTH (BIT_WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wptr),
    .wdata (wdata),
    .raddr (rptr),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) begin
        wptr <= wptr + 1'b1;
      end
      if (rd_en) begin
        rptr <= rptr + 1'b1;
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo with a queue reference model
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int BW    = 8;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [CW-1:0] count;
  logic          overflow;
  logic          clr_overflow = 1'b0;

  uart_rx_fifo_if #(.BIT_WIDTH(BW)) bus ();

  uart_rx_fifo #(.BIT_WIDTH(BW), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .count        (count),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  uart_rx_entry_t model_q[$];
  logic           model_ovf = 1'b0;

  // One clock of stimulus; the model applies the buffer rules to a plain queue.
  task automatic cycle(input logic v, input logic [7:0] b, input logic e,
                       input logic ordy, input logic clr);
    bit acc, rd, drop;
    bus.in_valid  = v;
    bus.in_byte   = b;
    bus.in_err    = e;
    bus.out_ready = ordy;
    clr_overflow  = clr;
    rd   = ordy && (model_q.size() != 0);
    acc  = v && ((model_q.size() < DEPTH) || ordy);
    drop = v && !acc;
    @(posedge clk);
    #1;
    if (rd) void'(model_q.pop_front());
    if (acc) model_q.push_back('{err: e, data: b});
    if (drop) model_ovf = 1'b1;
    else if (clr) model_ovf = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    clr_overflow  = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    model_q.delete();
    model_ovf = 1'b0;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    n_cmp++; if (count !== '0) begin n_bad++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    n_cmp++; if (bus.out_byte !== 8'h00) begin n_bad++; $display("FAIL reset_out_byte: got %h expected 00", bus.out_byte); end
    bus.in_valid = 1'b1;
    bus.in_byte  = 8'hA5;
    bus.in_err   = 1'b0;
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL no_bypass: got %b expected 0", bus.out_valid); end
    cycle(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid: got %b expected 1", bus.out_valid); end
    n_cmp++; if (bus.out_byte !== 8'hA5) begin n_bad++; $display("FAIL single_byte: got %h expected a5", bus.out_byte); end
    n_cmp++; if (count !== CW'(1)) begin n_bad++; $display("FAIL single_count: got %0d expected 1", count); end
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (count !== '0) begin n_bad++; $display("FAIL single_drain_count: got %0d expected 0", count); end
    n_cmp++; if (bus.out_byte !== 8'h00) begin n_bad++; $display("FAIL single_drain_byte: got %h expected 00", bus.out_byte); end
  endtask

  task automatic test_fill_order;
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    n_cmp++; if (count !== CW'(DEPTH)) begin n_bad++; $display("FAIL fill_count: got %0d expected %0d", count, DEPTH); end
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL fill_in_ready: got %b expected 0", bus.in_ready); end
    for (int i = 0; i < DEPTH; i++) begin
      n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_byte !== 8'(i)) begin
        n_bad++; $display("FAIL fill_order[%0d]: got valid=%b byte=%h expected valid=1 byte=%h", i, bus.out_valid, bus.out_byte, 8'(i));
      end
      cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL fill_empty: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_overflow;
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'($urandom_range(0, 8'h54)), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_set: got %b expected 1", overflow); end
    n_cmp++; if (count !== CW'(DEPTH)) begin n_bad++; $display("FAIL ovf_count: got %0d expected %0d", count, DEPTH); end
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_clear: got %b expected 0", overflow); end
    cycle(1'b1, 8'h55, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (overflow !== model_ovf || overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_set_wins: got %b expected 1", overflow); end
    for (int i = 0; i < DEPTH; i++) begin
      n_cmp++; if (bus.out_byte !== model_q[0].data || bus.out_byte === 8'h55) begin
        n_bad++; $display("FAIL ovf_drain[%0d]: got %h expected %h", i, bus.out_byte, model_q[0].data);
      end
      cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL ovf_empty: got %b expected 0", bus.out_valid); end
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_full_rw;
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'($urandom_range(0, 8'h76)), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (count !== CW'(DEPTH)) begin n_bad++; $display("FAIL full_rw_count: got %0d expected %0d", count, DEPTH); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL full_rw_overflow: got %b expected 0", overflow); end
    for (int i = 0; i < DEPTH; i++) begin
      n_cmp++; if (bus.out_byte !== model_q[0].data) begin
        n_bad++; $display("FAIL full_rw_drain[%0d]: got %h expected %h", i, bus.out_byte, model_q[0].data);
      end
      if (i == DEPTH - 1) begin
        n_cmp++; if (bus.out_byte !== 8'h77) begin n_bad++; $display("FAIL full_rw_last: got %h expected 77", bus.out_byte); end
      end
      cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_wrap_err;
    int idx = 0;
    int err_pos = $urandom_range(5, 35);
    int err_seen = 0;
    int budget = 0;
    logic ordy, v;
    logic [7:0] b;
    while ((idx < 40 || model_q.size() != 0) && budget < 2000) begin
      budget++;
      ordy = (idx >= 40) ? 1'b1 : 1'($urandom_range(0, 1));
      v = (idx < 40) && ((model_q.size() < DEPTH) || ordy);
      if (idx == err_pos) b = 8'h3C;
      else begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'h3C) b = 8'h3D;
      end
      n_cmp++; if (count !== CW'(model_q.size())) begin n_bad++; $display("FAIL wrap_count: got %0d expected %0d", count, model_q.size()); end
      if (model_q.size() != 0) begin
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_byte !== model_q[0].data || bus.out_err !== model_q[0].err) begin
          n_bad++; $display("FAIL wrap_head: got valid=%b byte=%h err=%b expected valid=1 byte=%h err=%b",
                            bus.out_valid, bus.out_byte, bus.out_err, model_q[0].data, model_q[0].err);
        end
        if (bus.out_err === 1'b1 && bus.out_byte === 8'h3C && ordy) err_seen++;
      end
      cycle(v, b, v && (idx == err_pos), ordy, 1'b0);
      if (v) idx++;
    end
    n_cmp++; if (budget >= 2000) begin n_bad++; $display("FAIL wrap_budget: got %0d cycles expected under 2000", budget); end
    n_cmp++; if (err_seen != 1) begin n_bad++; $display("FAIL wrap_err_seen: got %0d expected 1", err_seen); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL wrap_no_drop: got %b expected 0", overflow); end
  endtask

  task automatic test_async_reset;
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i + 8'h40), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH - 5; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (count !== CW'(5) || overflow !== 1'b1) begin n_bad++; $display("FAIL arst_pre: got count=%0d ovf=%b expected count=5 ovf=1", count, overflow); end
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    n_cmp++; if (count !== '0) begin n_bad++; $display("FAIL arst_count: got %0d expected 0", count); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL arst_out_valid: got %b expected 0", bus.out_valid); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL arst_overflow: got %b expected 0", overflow); end
    n_cmp++; if (bus.out_byte !== 8'h00 || bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL arst_outputs: got byte=%h in_ready=%b expected byte=00 in_ready=1", bus.out_byte, bus.in_ready); end
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_q.delete();
    model_ovf = 1'b0;
    cycle(1'b1, 8'h99, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (bus.out_byte !== 8'h99 || bus.out_err !== 1'b1 || count !== CW'(1)) begin
      n_bad++; $display("FAIL arst_resume: got byte=%h err=%b count=%0d expected byte=99 err=1 count=1", bus.out_byte, bus.out_err, count);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_byte   = '0;
    bus.in_err    = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_fill_order();
    test_overflow();
    test_full_rw();
    test_wrap_err();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
